// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the return-address stack and the
// link-address pipeline register path.
//   LINK_OFFSET : return address lies past the jump and its delay slot.
//   ras_op_e    : stack operation decoded from push/pop requests.
package pipe_pkg;

    localparam int LINK_OFFSET = 8;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_REPLACE = 2'd3
    } ras_op_e;

    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return RAS_PUSH;
            2'b01:   return RAS_POP;
            2'b11:   return RAS_REPLACE;
            default: return RAS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ras_if.sv
// Decode/fetch side bundle of the return-address stack.
//   master : decode/control drives push/pop/stall/flush, fetch consumes prediction
//   slave  : the stack itself
interface pipe_ras_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          stall;
    logic          flush;
    logic          push_valid;
    logic [AW-1:0] push_pc;
    logic          pop_valid;
    logic          pred_valid;
    logic [AW-1:0] pred_addr;
    logic          overflow;
    logic [CW-1:0] depth_cnt;

    modport master (
        output stall, flush, push_valid, push_pc, pop_valid,
        input  pred_valid, pred_addr, overflow, depth_cnt
    );

    modport slave (
        input  stall, flush, push_valid, push_pc, pop_valid,
        output pred_valid, pred_addr, overflow, depth_cnt
    );
endinterface

// File: rtl/pipe_ras_storage.sv
// DEPTH x AW return-address register file.
//   clk         : write clock
//   we/waddr/wdata : single synchronous write port
//   raddr/rdata : asynchronous read port (driven with tos-1 by the control)
// Contents are not reset; the control's count qualifies every read.
module ras_storage #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);
    logic [DEPTH-1:0][AW-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_ras.sv
// Return-address stack beside IF. Decode pushes jump PC + LINK_OFFSET on
// linking instructions and pops on JR $31; fetch gets a prediction decoded
// purely from registered state.
//   clk, rst_n : clock, async active-low reset
//   ras        : slave side of pipe_ras_if (stall/flush/push/pop in,
//                pred_valid/pred_addr/overflow/depth_cnt out)
// Storage is circular: when full, a push overwrites the oldest entry.
module pipe_ras
    import pipe_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    pipe_ras_if.slave ras
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] tos_q, tos_d, tos_m1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          we;
    logic [PW-1:0] waddr;
    logic [AW-1:0] wdata, rdata;
    logic          full, empty;
    ras_op_e       op;

    assign tos_m1 = tos_q - PW'(1);
    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wdata  = ras.push_pc + AW'(LINK_OFFSET);
    assign op     = ras_decode(ras.push_valid, ras.pop_valid);

    always_comb begin
        we    = 1'b0;
        waddr = tos_q;
        tos_d = tos_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (ras.flush) begin
            tos_d = '0;
            cnt_d = '0;
        end else if (!ras.stall) begin
            case (op)
                RAS_PUSH: begin
                    we    = 1'b1;
                    tos_d = tos_q + PW'(1);
                    // Full push wraps onto the oldest slot; count saturates.
                    if (full) ovf_d = 1'b1;
                    else      cnt_d = cnt_q + CW'(1);
                end
                RAS_POP: begin
                    // Underflow is silently ignored.
                    if (!empty) begin
                        tos_d = tos_m1;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RAS_REPLACE: begin
                    we = 1'b1;
                    if (empty) begin
                        tos_d = tos_q + PW'(1);
                        cnt_d = CW'(1);
                    end else begin
                        waddr = tos_m1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    ras_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (tos_m1),
        .rdata (rdata)
    );

    assign ras.pred_valid = !empty;
    assign ras.pred_addr  = empty ? '0 : rdata;
    assign ras.overflow   = ovf_q;
    assign ras.depth_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_ras.sv
module tb_pipe_ras;
    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ras_if #(.DEPTH(DEPTH), .AW(AW)) ifc ();
    pipe_ras #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .ras(ifc.slave));

    int total = 0;
    int bad   = 0;

    // Reference: a queue of return addresses, newest at the back.
    logic [AW-1:0] stk[$];
    bit            m_ovf;

    function automatic void model_step(bit pu, logic [AW-1:0] pc, bit po, bit st, bit fl);
        logic [AW-1:0] ra;
        ra = pc + 32'd8;
        m_ovf = 1'b0;
        if (fl) stk.delete();
        else if (!st) begin
            if (pu && po) begin
                if (stk.size() == 0) stk.push_back(ra);
                else stk[stk.size()-1] = ra;
            end else if (pu) begin
                if (stk.size() == DEPTH) begin
                    void'(stk.pop_front());
                    m_ovf = 1'b1;
                end
                stk.push_back(ra);
            end else if (po) begin
                if (stk.size() > 0) void'(stk.pop_back());
            end
        end
    endfunction

    task automatic check(string tag);
        logic          ev;
        logic [AW-1:0] ea;
        logic [3:0]    ec;
        ev = (stk.size() != 0);
        ea = ev ? stk[stk.size()-1] : '0;
        ec = 4'(stk.size());
        total++;
        assert (ifc.pred_valid === ev) else begin
            bad++; $error("FAIL %s pred_valid got=%0b exp=%0b", tag, ifc.pred_valid, ev);
        end
        total++;
        assert (ifc.pred_addr === ea) else begin
            bad++; $error("FAIL %s pred_addr got=%h exp=%h", tag, ifc.pred_addr, ea);
        end
        total++;
        assert (ifc.depth_cnt === ec) else begin
            bad++; $error("FAIL %s depth_cnt got=%0d exp=%0d", tag, ifc.depth_cnt, ec);
        end
        total++;
        assert (ifc.overflow === m_ovf) else begin
            bad++; $error("FAIL %s overflow got=%0b exp=%0b", tag, ifc.overflow, m_ovf);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, check 1 ns later.
    task automatic step(string tag, bit pu, logic [AW-1:0] pc, bit po, bit st = 0, bit fl = 0);
        ifc.push_valid = pu;
        ifc.push_pc    = pc;
        ifc.pop_valid  = po;
        ifc.stall      = st;
        ifc.flush      = fl;
        @(posedge clk);
        model_step(pu, pc, po, st, fl);
        #1;
        check(tag);
    endtask

    task automatic expect_addr(string tag, logic [AW-1:0] exp);
        total++;
        assert (ifc.pred_addr === exp) else begin
            bad++; $error("FAIL %s pred_addr got=%h exp=%h", tag, ifc.pred_addr, exp);
        end
    endtask

    initial begin
        ifc.push_valid = 0; ifc.push_pc = '0; ifc.pop_valid = 0;
        ifc.stall = 0; ifc.flush = 0;
        m_ovf = 0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1; check("reset");
        #3 rst_n = 1'b1;
        step("idle", 0, '0, 0);

        // Single push / pop.
        step("push1", 1, 32'h0040_0010, 0);
        expect_addr("push1_lit", 32'h0040_0018);
        step("pop1", 0, '0, 1);

        // Nine pushes into an 8-deep stack, then drain.
        for (int i = 1; i <= 9; i++) step($sformatf("fill%0d", i), 1, 32'h100 * i, 0);
        step("post_ovf", 0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            expect_addr($sformatf("drain_top%0d", i), 32'h100 * (9 - i) + 32'h8);
            step($sformatf("drain%0d", i), 0, '0, 1);
        end

        // Simultaneous push+pop replaces the top.
        step("r_push1", 1, 32'h1000, 0);
        step("r_push2", 1, 32'h2000, 0);
        step("replace", 1, 32'h3000, 1);
        expect_addr("replace_lit", 32'h3008);
        step("r_pop", 0, '0, 1);
        expect_addr("r_pop_lit", 32'h1008);
        step("r_pop2", 0, '0, 1);
        step("replace_empty", 1, 32'h4000, 1);

        // Stall blocks push.
        step("stall_push", 1, 32'h5000, 0, 1, 0);
        step("stall_pop", 0, '0, 1, 1, 0);

        // Flush with three entries.
        step("f_push1", 1, 32'h6000, 0);
        step("f_push2", 1, 32'h7000, 0);
        step("flush", 1, 32'h8000, 1, 1, 1);

        // Pop on empty, then a push must land at slot 0 again.
        step("pop_empty", 0, '0, 1);
        step("pop_empty2", 0, '0, 1);
        step("after_empty", 1, 32'h9000, 0);

        // Overflow must clear when a stall follows a full push.
        for (int i = 0; i < 8; i++) step("ovf_fill", 1, 32'hA000 + 32'h10 * i, 0);
        step("ovf_push", 1, 32'hB000, 0);
        step("ovf_stall", 1, 32'hC000, 0, 1, 0);
        step("ovf_flush", 0, '0, 0, 0, 1);

        // Async reset mid-cycle with four entries.
        for (int i = 0; i < 4; i++) step("ar_fill", 1, 32'hD000 + 32'h4 * i, 0);
        #2 rst_n = 1'b0;
        stk.delete(); m_ovf = 0;
        #1; check("async_reset");
        #1 rst_n = 1'b1;
        step("post_reset", 0, '0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit pu, po, st, fl;
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 40);
            st = ($urandom_range(0, 99) < 10);
            fl = ($urandom_range(0, 99) < 4);
            step("rand", pu, $urandom, po, st, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ras.md
Name: pipe_ras

Overview:
- Return-address stack that consumes link addresses generated by JAL/JALR/BGEZAL/BLTZAL.
- Predicts targets for JR $31 at fetch.
- Sits beside the IF stage. Decode pushes the return address (jump PC + 8, after the delay slot) when a linking instruction is seen, and pops when JR $31 is decoded.
- Gives fetch a registered prediction instead of waiting for the register-file read in EX.

Parameters:
- DEPTH, 8, number of stack entries; power of two, 2..32.
- AW, 32, address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold (IF/ID write disabled); blocks all state updates.
- flush  in  1  mispredict/exception recovery; empties stack.
- push_valid  in  1  linking instruction in ID this cycle.
- push_pc  in  AW  PC of the linking instruction.
- pop_valid  in  1  JR $31 in ID this cycle.
- pred_valid  out  1  stack non-empty; pred_addr meaningful.
- pred_addr  out  AW  current top-of-stack return address.
- overflow  out  1  one-cycle pulse when a push overwrote the oldest entry.
- depth_cnt  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0):
  - tos pointer = 0; count = 0; overflow = 0.
  - pred_valid = 0; pred_addr = 0.
  - Entry storage need not be cleared.
- Storage is a circular buffer of DEPTH×AW registers with tos pointer and count; pointer arithmetic is modulo DEPTH.
- Outputs:
  - pred_addr = entry[tos-1] when count>0, else 0.
  - pred_valid = (count != 0).
  - Both are decoded from registered state, with no combinational path from inputs.
- Push (push_valid & !pop_valid & !stall & !flush):
  - entry[tos] <= push_pc + 8 (wraps modulo 2^AW); tos <= tos+1.
  - count <= min(count+1, DEPTH).
  - If count was DEPTH, the oldest entry is overwritten and overflow pulses 1 for the next cycle.
- Pop (pop_valid & !push_valid & !stall & !flush):
  - If count>0: tos <= tos-1; count <= count-1.
  - If count==0: no change (underflow ignored; pred_valid was 0, so fetch does not use it).
- Simultaneous push and pop (JALR $31,$31 style):
  - Acts as a replace: entry[tos-1] <= push_pc + 8; tos and count unchanged.
  - If count==0, acts as a plain push.
- Stall: no state changes and inputs ignored; outputs hold. overflow clears to 0.
- Flush: has priority over push/pop/stall. count <= 0, tos <= 0 next cycle; pred_valid is 0 from the following cycle.
- Latency: a push or pop is visible on pred_addr/pred_valid exactly one cycle after the enabling edge.
- Reset asserted mid-operation clears state immediately (async); after release, the stack is empty.
- depth_cnt = count.

Decomposition:
- Shared package pipe_pkg holds:
  - LINK_OFFSET = 8 (return-address offset past the delay slot), also used by the link-address pipeline register path.
  - The ras_op enum {RAS_NONE, RAS_PUSH, RAS_POP, RAS_REPLACE}, decoded from push_valid/pop_valid.
- One natural sub-module: ras_storage (DEPTH×AW register file, one write port, one async read port indexed by tos-1).
- The pointer/count control stays in pipe_ras.

Test Plan:
- Reset then idle: pred_valid=0, depth_cnt=0, pred_addr=0.
- Push push_pc=0x00400010:
  - Next cycle pred_valid=1, pred_addr=0x00400018, depth_cnt=1.
  - Then pop: next cycle pred_valid=0, depth_cnt=0.
- Push 9 times with DEPTH=8 (pcs 0x100,0x200,…,0x900):
  - overflow pulses once after the 9th push; depth_cnt=8.
  - 8 pops return 0x908,0x808,…,0x208 in order, then pred_valid=0.
- Stack holds 0x1008, 0x2008 (top); assert push_valid & pop_valid with push_pc=0x3000:
  - pred_addr=0x3008, depth_cnt unchanged at 2.
  - One pop then shows 0x1008.
- Push with stall=1: no change to depth_cnt/pred_addr.
- Push with flush=1 and count=3: depth_cnt=0 next cycle.
- Pop on empty: depth_cnt stays 0, no pointer wrap.
- Assert rst_n=0 asynchronously between edges with 4 entries: outputs clear before the next clk edge.
